// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry result FIFO toward the register file
// plus the architectural flag register (psr) and the carry fed back to the ALU.
module alu_writeback_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    input  logic [7:0]        opcode,
    input  logic [REG_AW-1:0] dest,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_dest,
    output logic [4:0]        psr,
    output logic              cin
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [REG_AW-1:0] dest0_q, dest0_d, dest1_q, dest1_d;
    logic [4:0]        psr_q, psr_d;

    logic [3:0] op_hi;
    logic [3:0] op_lo;
    logic       is_nop;
    logic       is_cmp;
    logic       accept;
    logic       push;
    logic       pop;

    assign op_hi = opcode[7:4];
    assign op_lo = opcode[3:0];

    // Opcodes with no architectural effect in this stage
    assign is_nop = ((op_hi == 4'h0) &&
                     ((op_lo == 4'h0) || (op_lo == 4'hA) ||
                      (op_lo == 4'hC) || (op_lo == 4'hD) ||
                      (op_lo == 4'hE))) ||
                    !((op_hi == 4'h0) || (op_hi == 4'h5) ||
                      (op_hi == 4'h6) || (op_hi == 4'h7) ||
                      (op_hi == 4'h8));
    assign is_cmp = (opcode == 8'h0B) || (opcode == 8'h0F);

    assign in_ready = (count_q != CNT_FULL);
    assign wb_valid = (count_q != CNT_EMPTY);
    assign wb_data  = data0_q;
    assign wb_dest  = dest0_q;
    assign psr      = psr_q;
    assign cin      = psr_q[3];

    assign accept = in_valid && in_ready && !flush;
    assign push   = accept && !is_nop && !is_cmp;
    assign pop    = wb_valid && wb_ready && !flush;

    always_comb begin
        count_d = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        dest0_d = dest0_q;
        dest1_d = dest1_q;
        psr_d   = psr_q;
        if (flush) begin
            count_d = CNT_EMPTY;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (accept && !is_nop) begin
                psr_d = alu_flags;
            end
            // Slot 0 is always the head; it only moves on a pop
            unique case (1'b1)
                pop && (count_q == CNT_FULL): begin
                    data0_d = data1_q;
                    dest0_d = dest1_q;
                end
                pop && push: begin
                    data0_d = alu_c;
                    dest0_d = dest;
                end
                !pop && push && (count_q == CNT_EMPTY): begin
                    data0_d = alu_c;
                    dest0_d = dest;
                end
                !pop && push && (count_q == CNT_ONE): begin
                    data1_d = alu_c;
                    dest1_d = dest;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            dest0_q <= '0;
            dest1_q <= '0;
            psr_q   <= 5'b00000;
        end else begin
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            dest0_q <= dest0_d;
            dest1_q <= dest1_d;
            psr_q   <= psr_d;
        end
    end

endmodule
